// File: rtl/grey_sobel_edge.sv
// grey_sobel_edge: 3x3 Sobel gradient magnitude and edge flag on the decimated grey stream.
// Two column-indexed line memories supply lines r-1 and r-2; a two-column window holds c-2..c-1.
module grey_sobel_edge #(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240,
  parameter int unsigned DW    = 12
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSOF,
  input  logic [DW-1:0] iGrey,
  input  logic          iDVAL,
  input  logic [DW-1:0] iThresh,
  output logic [DW-1:0] oMag,
  output logic          oEdge,
  output logic          oDVAL,
  output logic [10:0]   oX,
  output logic [10:0]   oY,
  output logic          oEOF
);

  localparam int unsigned CW = 11;              // coordinate width
  localparam int unsigned AW = $clog2(IMG_W);   // line-memory address width
  localparam int unsigned GW = DW + 4;          // signed gradient width
  localparam int unsigned MW = GW - 1;          // |Gx|+|Gy| width
  localparam logic [MW-1:0] MAG_MAX = MW'({DW{1'b1}});

  // Column/row counters and acceptance
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [CW-1:0] col_cur, row_cur;
  logic          acc;
  logic [AW-1:0] lb_idx;

  // Line memories (contents never reset) and window columns c-2 (wa) and c-1 (wb)
  logic [DW-1:0] lb1_mem [IMG_W];
  logic [DW-1:0] lb2_mem [IMG_W];
  logic [DW-1:0] up1, up2;
  logic [2:0][DW-1:0] wa_q, wa_d, wb_q, wb_d, col_new;

  // Pipeline registers
  logic signed [GW-1:0] gx_c, gy_c;
  logic                 s1_vld_q, s1_vld_d, s1_eof_q, s1_eof_d;
  logic signed [GW-1:0] s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
  logic [CW-1:0]        s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [MW-1:0]        abs_gx, abs_gy, mag_c;
  logic [DW-1:0]        sat_c;
  logic [DW-1:0]        mag_q, mag_d;
  logic                 edge_q, edge_d, dval_q, dval_d, eof_q, eof_d;
  logic [CW-1:0]        x_q, x_d, y_q, y_d;

  function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] p);
    return $signed(GW'(p));
  endfunction

  // Counter update; iSOF forces the current pixel to (0,0), rows past the frame are ignored
  always_comb begin
    col_cur = iSOF ? '0 : col_q;
    row_cur = iSOF ? '0 : row_q;
    acc     = iDVAL && (row_cur < CW'(IMG_H));
    lb_idx  = AW'(col_cur);
    col_d   = col_cur;
    row_d   = row_cur;
    if (acc) begin
      if (col_cur == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_cur + CW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
    end
  end

  // Same-column pixels of lines r-1 and r-2
  always_comb begin
    up1 = lb1_mem[lb_idx];
    up2 = lb2_mem[lb_idx];
  end

  // Line memories advance only on accepted pixels
  always_ff @(posedge iCLK) begin
    if (acc) begin
      lb1_mem[lb_idx] <= iGrey;
      lb2_mem[lb_idx] <= up1;
    end
  end

  // Window shift and Sobel gradients over columns c-2 (wa), c-1 (wb), c (incoming)
  always_comb begin
    col_new = {iGrey, up1, up2};
    wa_d    = wa_q;
    wb_d    = wb_q;
    if (acc) begin
      wa_d = wb_q;
      wb_d = col_new;
    end
    gx_c = (ext(up2) + ext(up1) + ext(up1) + ext(iGrey))
         - (ext(wa_q[0]) + ext(wa_q[1]) + ext(wa_q[1]) + ext(wa_q[2]));
    gy_c = (ext(wa_q[2]) + ext(wb_q[2]) + ext(wb_q[2]) + ext(iGrey))
         - (ext(wa_q[0]) + ext(wb_q[0]) + ext(wb_q[0]) + ext(up2));
  end

  // Stage 1: capture gradients for interior pixels only
  always_comb begin
    s1_vld_d = acc && (row_cur >= CW'(2)) && (col_cur >= CW'(2));
    s1_eof_d = s1_vld_d && (col_cur == CW'(IMG_W - 1)) && (row_cur == CW'(IMG_H - 1));
    s1_gx_d  = s1_vld_d ? gx_c : s1_gx_q;
    s1_gy_d  = s1_vld_d ? gy_c : s1_gy_q;
    s1_x_d   = s1_vld_d ? (col_cur - CW'(1)) : s1_x_q;
    s1_y_d   = s1_vld_d ? (row_cur - CW'(1)) : s1_y_q;
  end

  // Stage 2: magnitude, saturation and threshold; outputs hold while idle
  always_comb begin
    abs_gx = s1_gx_q[GW-1] ? MW'(-s1_gx_q) : MW'(s1_gx_q);
    abs_gy = s1_gy_q[GW-1] ? MW'(-s1_gy_q) : MW'(s1_gy_q);
    mag_c  = abs_gx + abs_gy;
    sat_c  = (mag_c > MAG_MAX) ? '1 : DW'(mag_c);
    dval_d = s1_vld_q;
    eof_d  = s1_vld_q && s1_eof_q;
    mag_d  = s1_vld_q ? sat_c : mag_q;
    edge_d = s1_vld_q ? (sat_c >= iThresh) : edge_q;
    x_d    = s1_vld_q ? s1_x_q : x_q;
    y_d    = s1_vld_q ? s1_y_q : y_q;
  end

  // State registers
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      col_q    <= '0;
      row_q    <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_eof_q <= 1'b0;
      s1_gx_q  <= '0;
      s1_gy_q  <= '0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      mag_q    <= '0;
      edge_q   <= 1'b0;
      dval_q   <= 1'b0;
      eof_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      s1_vld_q <= s1_vld_d;
      s1_eof_q <= s1_eof_d;
      s1_gx_q  <= s1_gx_d;
      s1_gy_q  <= s1_gy_d;
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
      mag_q    <= mag_d;
      edge_q   <= edge_d;
      dval_q   <= dval_d;
      eof_q    <= eof_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign oMag  = mag_q;
  assign oEdge = edge_q;
  assign oDVAL = dval_q;
  assign oX    = x_q;
  assign oY    = y_q;
  assign oEOF  = eof_q;

endmodule

// File: tb/tb_grey_sobel_edge.sv
// tb_grey_sobel_edge: directed bench; an 8x6 instance for detailed scenarios, a full-size one for the frame count.
module tb_grey_sobel_edge;

  localparam int unsigned DW   = 12;
  localparam int unsigned SW   = 8;
  localparam int unsigned SH   = 6;
  localparam int unsigned BW   = 320;
  localparam int unsigned BH   = 240;
  localparam int unsigned NOUT = (SW - 2) * (SH - 2);

  typedef struct {
    logic [DW-1:0] mag;
    logic          edg;
    logic [10:0]   x;
    logic [10:0]   y;
    logic          eof;
    int            cyc;
  } rec_t;

  logic clk = 1'b0;
  logic s_rst_n, s_sof, s_dval, s_edge, s_odv, s_eof;
  logic [DW-1:0] s_grey, s_th, s_mag;
  logic [10:0] s_x, s_y;
  logic b_rst_n, b_sof, b_dval, b_edge, b_odv, b_eof;
  logic [DW-1:0] b_grey, b_th, b_mag;
  logic [10:0] b_x, b_y;

  grey_sobel_edge #(.IMG_W(SW), .IMG_H(SH), .DW(DW)) u_small (
    .iCLK(clk), .iRST(s_rst_n), .iSOF(s_sof), .iGrey(s_grey), .iDVAL(s_dval), .iThresh(s_th),
    .oMag(s_mag), .oEdge(s_edge), .oDVAL(s_odv), .oX(s_x), .oY(s_y), .oEOF(s_eof)
  );

  grey_sobel_edge #(.IMG_W(BW), .IMG_H(BH), .DW(DW)) u_big (
    .iCLK(clk), .iRST(b_rst_n), .iSOF(b_sof), .iGrey(b_grey), .iDVAL(b_dval), .iThresh(b_th),
    .oMag(b_mag), .oEdge(b_edge), .oDVAL(b_odv), .oX(b_x), .oY(b_y), .oEOF(b_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int hold_bad = 0;
  int b_cnt = 0;
  int b_bad = 0;
  int b_eof_cnt = 0;
  logic [10:0] b_eof_x = '0;
  logic [10:0] b_eof_y = '0;
  logic [34:0] s_last = '0;
  rec_t s_q[$];
  rec_t exp_q[$];
  rec_t ref_q[$];
  logic [DW-1:0] frm [SH][SW];

  always @(posedge clk) cyc = cyc + 1;

  // Output capture on the falling edge
  always @(negedge clk) begin
    if (!s_rst_n) begin
      s_last = '0;
    end else if (s_odv) begin
      s_q.push_back('{mag: s_mag, edg: s_edge, x: s_x, y: s_y, eof: s_eof, cyc: cyc});
      s_last = {s_mag, s_edge, s_x, s_y};
    end else if (({s_mag, s_edge, s_x, s_y} !== s_last) || (s_eof !== 1'b0)) begin
      hold_bad++;
    end
    if (b_odv) begin
      b_cnt++;
      if (b_mag !== '0 || b_edge !== 1'b0) b_bad++;
      if (b_eof) begin
        b_eof_cnt++;
        b_eof_x = b_x;
        b_eof_y = b_y;
      end
    end
  end

  // Independent Sobel reference built straight from the frame array
  function automatic rec_t model(input int r, input int c);
    int p [3][3];
    int gx, gy, m;
    rec_t e;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(frm[r-2+i][c-2+j]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 4095) m = 4095;
    e.mag = DW'(m);
    e.edg = (m >= int'(s_th));
    e.x   = 11'(c - 1);
    e.y   = 11'(r - 1);
    e.eof = (r == SH - 1) && (c == SW - 1);
    e.cyc = 0;
    return e;
  endfunction

  // One small-instance pixel, then optional idle cycles (called at posedge+1)
  task automatic s_px(input logic [DW-1:0] g, input logic sof, input int gap);
    s_grey = g; s_sof = sof; s_dval = 1'b1;
    @(posedge clk); #1;
    s_dval = 1'b0; s_sof = 1'b0; s_grey = '0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Streams frm into the small instance and queues expected outputs with their drive cycle
  task automatic run_frame(input int gap_max, input logic sof_first, input int npix);
    rec_t e;
    int r, c;
    for (int i = 0; i < npix; i++) begin
      r = i / int'(SW);
      c = i % int'(SW);
      if (r >= 2 && c >= 2) begin
        e = model(r, c);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      s_px(frm[r][c], sof_first && (i == 0), (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic fill_random();
    for (int r = 0; r < int'(SH); r++)
      for (int c = 0; c < int'(SW); c++)
        frm[r][c] = DW'($urandom);
  endtask

  task automatic test_reset();
    n_vec++;
    if ({s_mag, s_edge, s_odv, s_x, s_y, s_eof} !== '0) begin
      n_err++;
      $display("FAIL reset_small: got mag=%0d edge=%0b dval=%0b x=%0d y=%0d eof=%0b want all 0",
               s_mag, s_edge, s_odv, s_x, s_y, s_eof);
    end
    n_vec++;
    if ({b_mag, b_edge, b_odv, b_x, b_y, b_eof} !== '0) begin
      n_err++;
      $display("FAIL reset_big: got mag=%0d edge=%0b dval=%0b x=%0d y=%0d eof=%0b want all 0",
               b_mag, b_edge, b_odv, b_x, b_y, b_eof);
    end
  endtask

  task automatic test_full_flat();
    b_th = DW'(1); b_grey = DW'(1000); b_sof = 1'b1; b_dval = 1'b1;
    @(posedge clk); #1;
    b_sof = 1'b0;
    repeat (BW * BH - 1) begin @(posedge clk); #1; end
    b_dval = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_vec++;
    if (b_cnt != 75684) begin n_err++; $display("FAIL flat_count: got %0d want 75684", b_cnt); end
    n_vec++;
    if (b_bad != 0) begin n_err++; $display("FAIL flat_value: %0d outputs with nonzero mag/edge, want 0", b_bad); end
    n_vec++;
    if (b_eof_cnt != 1) begin n_err++; $display("FAIL flat_eof_count: got %0d want 1", b_eof_cnt); end
    n_vec++;
    if (b_eof_x !== 11'd318 || b_eof_y !== 11'd238) begin
      n_err++; $display("FAIL flat_eof_xy: got (%0d,%0d) want (318,238)", b_eof_x, b_eof_y);
    end
  endtask

  task automatic test_ramp();
    int n;
    logic exp_edge;
    for (int r = 0; r < int'(SH); r++)
      for (int c = 0; c < int'(SW); c++)
        frm[r][c] = DW'(10 * c);
    for (int pass = 0; pass < 2; pass++) begin
      s_th = (pass == 0) ? DW'(80) : DW'(81);
      exp_edge = (pass == 0);
      s_q.delete(); exp_q.delete();
      run_frame(0, pass == 1, int'(SW * SH));
      n_vec++;
      if (s_q.size() != NOUT) begin
        n_err++; $display("FAIL ramp%0d_count: got %0d want %0d", 80 + pass, s_q.size(), NOUT);
      end
      n = (s_q.size() < exp_q.size()) ? s_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        n_vec++;
        if (s_q[i].mag !== DW'(80) || s_q[i].edg !== exp_edge ||
            s_q[i].x !== 11'(1 + i % int'(SW - 2)) || s_q[i].y !== 11'(1 + i / int'(SW - 2)) ||
            (s_q[i].cyc - exp_q[i].cyc) != 2) begin
          n_err++;
          $display("FAIL ramp%0d[%0d]: got mag=%0d edge=%0b x=%0d y=%0d lat=%0d want mag=80 edge=%0b x=%0d y=%0d lat=2",
                   80 + pass, i, s_q[i].mag, s_q[i].edg, s_q[i].x, s_q[i].y, s_q[i].cyc - exp_q[i].cyc,
                   exp_edge, 1 + i % int'(SW - 2), 1 + i / int'(SW - 2));
        end
      end
    end
  endtask

  task automatic test_step();
    int n, xx;
    logic [DW-1:0] em;
    for (int r = 0; r < int'(SH); r++)
      for (int c = 0; c < int'(SW); c++)
        frm[r][c] = (c >= int'(SW / 2)) ? DW'(4095) : DW'(0);
    s_th = DW'(4095);
    s_q.delete(); exp_q.delete();
    run_frame(0, 1'b1, int'(SW * SH));
    n_vec++;
    if (s_q.size() != NOUT) begin n_err++; $display("FAIL step_count: got %0d want %0d", s_q.size(), NOUT); end
    n = (s_q.size() < int'(NOUT)) ? s_q.size() : int'(NOUT);
    for (int i = 0; i < n; i++) begin
      xx = 1 + i % int'(SW - 2);
      em = (xx == int'(SW / 2) - 1 || xx == int'(SW / 2)) ? DW'(4095) : DW'(0);
      n_vec++;
      if (s_q[i].mag !== em || s_q[i].edg !== (em == DW'(4095)) || s_q[i].x !== 11'(xx)) begin
        n_err++;
        $display("FAIL step[%0d]: got mag=%0d edge=%0b x=%0d want mag=%0d edge=%0b x=%0d",
                 i, s_q[i].mag, s_q[i].edg, s_q[i].x, em, em == DW'(4095), xx);
      end
    end
  endtask

  task automatic test_gaps();
    int n;
    fill_random();
    s_th = DW'($urandom_range(1500, 100));
    s_q.delete(); exp_q.delete();
    run_frame(0, 1'b1, int'(SW * SH));
    ref_q = s_q;
    n = (ref_q.size() < exp_q.size()) ? ref_q.size() : exp_q.size();
    n_vec++;
    if (ref_q.size() != NOUT) begin n_err++; $display("FAIL nogap_count: got %0d want %0d", ref_q.size(), NOUT); end
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if ({ref_q[i].mag, ref_q[i].edg, ref_q[i].x, ref_q[i].y, ref_q[i].eof} !==
          {exp_q[i].mag, exp_q[i].edg, exp_q[i].x, exp_q[i].y, exp_q[i].eof}) begin
        n_err++;
        $display("FAIL nogap[%0d]: got mag=%0d edge=%0b x=%0d y=%0d want mag=%0d edge=%0b x=%0d y=%0d", i,
                 ref_q[i].mag, ref_q[i].edg, ref_q[i].x, ref_q[i].y, exp_q[i].mag, exp_q[i].edg, exp_q[i].x, exp_q[i].y);
      end
    end
    s_q.delete(); exp_q.delete();
    run_frame(5, 1'b1, int'(SW * SH));
    n_vec++;
    if (s_q.size() != ref_q.size()) begin
      n_err++; $display("FAIL gap_count: got %0d want %0d", s_q.size(), ref_q.size());
    end
    n = (s_q.size() < ref_q.size()) ? s_q.size() : ref_q.size();
    if (exp_q.size() < n) n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if ({s_q[i].mag, s_q[i].edg, s_q[i].x, s_q[i].y, s_q[i].eof} !==
          {ref_q[i].mag, ref_q[i].edg, ref_q[i].x, ref_q[i].y, ref_q[i].eof} ||
          (s_q[i].cyc - exp_q[i].cyc) != 2) begin
        n_err++;
        $display("FAIL gap[%0d]: got mag=%0d x=%0d y=%0d lat=%0d want mag=%0d x=%0d y=%0d lat=2", i,
                 s_q[i].mag, s_q[i].x, s_q[i].y, s_q[i].cyc - exp_q[i].cyc, ref_q[i].mag, ref_q[i].x, ref_q[i].y);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    fill_random();
    s_q.delete(); exp_q.delete();
    for (int i = 0; i < 3 * int'(SW) + 4; i++)
      s_px(frm[i / int'(SW)][i % int'(SW)], i == 0, 0);
    s_q.delete();
    s_rst_n = 1'b0;
    repeat (3) s_px(DW'(4095), 1'b0, 0);
    s_rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    n_vec++;
    if (s_q.size() != 0) begin n_err++; $display("FAIL rstmid_spurious: got %0d outputs want 0", s_q.size()); end
    fill_random();
    s_th = DW'($urandom_range(2000, 0));
    s_q.delete(); exp_q.delete();
    run_frame(1, 1'b1, int'(SW * SH));
    n_vec++;
    if (s_q.size() != NOUT) begin n_err++; $display("FAIL rstmid_count: got %0d want %0d", s_q.size(), NOUT); end
    n = (s_q.size() < exp_q.size()) ? s_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if ({s_q[i].mag, s_q[i].edg, s_q[i].x, s_q[i].y, s_q[i].eof} !==
          {exp_q[i].mag, exp_q[i].edg, exp_q[i].x, exp_q[i].y, exp_q[i].eof} ||
          (s_q[i].cyc - exp_q[i].cyc) != 2) begin
        n_err++;
        $display("FAIL rstmid[%0d]: got mag=%0d edge=%0b x=%0d y=%0d lat=%0d want mag=%0d edge=%0b x=%0d y=%0d lat=2", i,
                 s_q[i].mag, s_q[i].edg, s_q[i].x, s_q[i].y, s_q[i].cyc - exp_q[i].cyc,
                 exp_q[i].mag, exp_q[i].edg, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_sof_extra();
    int n, neof;
    fill_random();
    s_th = DW'(600);
    s_q.delete(); exp_q.delete();
    run_frame(2, 1'b1, int'(SW * SH));
    for (int i = 0; i < 10; i++) s_px(DW'($urandom), 1'b0, 0);
    repeat (4) begin @(posedge clk); #1; end
    n_vec++;
    if (s_q.size() != NOUT) begin n_err++; $display("FAIL extra_count: got %0d want %0d", s_q.size(), NOUT); end
    neof = 0;
    foreach (s_q[i]) if (s_q[i].eof) neof++;
    n_vec++;
    if (neof != 1 || s_q.size() == 0 || !s_q[s_q.size()-1].eof ||
        s_q[s_q.size()-1].x !== 11'(SW - 2) || s_q[s_q.size()-1].y !== 11'(SH - 2)) begin
      n_err++;
      $display("FAIL extra_eof: got %0d eof pulses, last x=%0d y=%0d want 1 on last at x=%0d y=%0d",
               neof, (s_q.size() > 0) ? s_q[s_q.size()-1].x : 11'd0, (s_q.size() > 0) ? s_q[s_q.size()-1].y : 11'd0,
               SW - 2, SH - 2);
    end
    fill_random();
    s_q.delete(); exp_q.delete();
    run_frame(0, 1'b1, int'(SW * SH));
    n_vec++;
    if (s_q.size() != NOUT) begin n_err++; $display("FAIL sofdv_count: got %0d want %0d", s_q.size(), NOUT); end
    n = (s_q.size() < exp_q.size()) ? s_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if ({s_q[i].mag, s_q[i].edg, s_q[i].x, s_q[i].y, s_q[i].eof} !==
          {exp_q[i].mag, exp_q[i].edg, exp_q[i].x, exp_q[i].y, exp_q[i].eof}) begin
        n_err++;
        $display("FAIL sofdv[%0d]: got mag=%0d edge=%0b x=%0d y=%0d want mag=%0d edge=%0b x=%0d y=%0d", i,
                 s_q[i].mag, s_q[i].edg, s_q[i].x, s_q[i].y, exp_q[i].mag, exp_q[i].edg, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_hold();
    n_vec++;
    if (hold_bad != 0) begin
      n_err++; $display("FAIL hold: %0d idle cycles changed outputs or raised oEOF, want 0", hold_bad);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst_n = 1'b0; b_rst_n = 1'b0;
    s_sof = 1'b0; s_dval = 1'b1; s_grey = '0; s_th = '0;
    b_sof = 1'b0; b_dval = 1'b1; b_grey = '0; b_th = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    s_dval = 1'b0; b_dval = 1'b0;
    s_rst_n = 1'b1; b_rst_n = 1'b1;
    @(posedge clk); #1;
    fork
      test_full_flat();
      begin
        test_ramp();
        test_step();
        test_gaps();
        test_reset_mid();
        test_sof_extra();
        test_hold();
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
